// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage. Owns the program counter and the IF/ID
//            pipeline register. Selects the next PC from branch redirect,
//            hold (halt or stall) or the external incrementer's pc_inc.
//            Inserts NOP bubbles on branch flush and while halted.
// Revision : 1.0 - initial release
//
// Ports:
//   clk            in   1        clock, rising edge
//   reset_n        in   1        asynchronous active-low reset
//   pc             out  PC_W     current PC (to incrementer and imem)
//   pc_inc         in   PC_W     pc+1 from the external incrementer
//   imem_data      in   INSTR_W  instruction at address pc
//   stall          in   1        hold PC and IF/ID
//   branch_taken   in   1        redirect to branch_target, flush IF/ID
//   branch_target  in   PC_W     redirect address
//   resume         in   1        leave the halted state
//   if_id_instr    out  INSTR_W  registered instruction for decode
//   if_id_pc_inc   out  PC_W     registered pc_inc with the instruction
//   if_id_valid    out  1        IF/ID holds a real instruction
//   halted         out  1        fetch is halted
//
// Optional feature (macro FETCH_STATS_EN):
//   stat_fetched   out  16       saturating count of valid IF/ID loads
//   stat_stalls    out  16       saturating count of stall edges in RUN
//   stat_flushes   out  16       saturating count of branch_taken edges
// ============================================================================
module fetch_stage #(
  parameter int                 PC_W        = 7,
  parameter int                 INSTR_W     = 16,
  parameter logic [PC_W-1:0]    RESET_PC    = 7'd0,
  parameter logic [3:0]         HALT_OPCODE = 4'hF,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    pc_inc,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               resume,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_inc,
  output logic               if_id_valid,
  output logic               halted
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stat_fetched,
  output logic [15:0]        stat_stalls,
  output logic [15:0]        stat_flushes
`endif
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      pc_inc_q, pc_inc_d;
  logic                 valid_q, valid_d;

  // Next-state: branch beats halt, halt beats stall, stall beats sequential.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_inc_d = pc_inc_q;
    valid_d  = valid_q;

    if (branch_taken) begin
      // Redirect also releases a halt; IF/ID gets a one-cycle bubble.
      pc_d    = branch_target;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (state_q == ST_HALTED) begin
      // PC parks on the instruction after the halt so resume refetches it.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      if (resume) begin
        state_d = ST_RUN;
      end
    end else if (stall) begin
      // Hold everything.
    end else begin
      pc_d     = pc_inc;
      instr_d  = imem_data;
      pc_inc_d = pc_inc;
      valid_d  = 1'b1;
      // The halt instruction itself still goes to decode as valid.
      if (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE) begin
        state_d = ST_HALTED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_inc_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_inc_q <= pc_inc_d;
      valid_q  <= valid_d;
    end
  end

  assign pc           = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc_inc = pc_inc_q;
  assign if_id_valid  = valid_q;
  assign halted       = (state_q == ST_HALTED);

`ifdef FETCH_STATS_EN
  logic        fetch_ev, stall_ev, flush_ev;
  logic [15:0] fetched_q, stalls_q, flushes_q;

  assign flush_ev = branch_taken;
  assign stall_ev = !branch_taken && (state_q == ST_RUN) && stall;
  assign fetch_ev = !branch_taken && (state_q == ST_RUN) && !stall;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetched_q <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      if (fetch_ev && (fetched_q != 16'hFFFF)) fetched_q <= fetched_q + 16'd1;
      if (stall_ev && (stalls_q  != 16'hFFFF)) stalls_q  <= stalls_q  + 16'd1;
      if (flush_ev && (flushes_q != 16'hFFFF)) flushes_q <= flushes_q + 16'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_stalls  = stalls_q;
  assign stat_flushes = flushes_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. Directed table of cycles
//            from reset, hand-written halt/branch/async-reset sequences, and
//            a randomized run against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  pc;
  logic [6:0]  pc_inc;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [6:0]  branch_target = 7'd0;
  logic        resume = 1'b0;
  logic [15:0] if_id_instr;
  logic [6:0]  if_id_pc_inc;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched, stat_stalls, stat_flushes;
`endif

  logic [15:0] mem [128];

  // External incrementer and instruction memory.
  assign pc_inc    = pc + 7'd1;
  assign imem_data = mem[pc];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc            (pc),
    .pc_inc        (pc_inc),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .resume        (resume),
    .if_id_instr   (if_id_instr),
    .if_id_pc_inc  (if_id_pc_inc),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched  (stat_fetched),
    .stat_stalls   (stat_stalls),
    .stat_flushes  (stat_flushes)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state (architectural view of the stage).
  int          m_pc;
  bit          m_halted;
  logic [15:0] m_instr;
  int          m_pcinc;
  bit          m_valid;
  int          m_fetched, m_stalls, m_flushes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_halted = 0; m_instr = 16'h0000; m_pcinc = 0; m_valid = 0;
    m_fetched = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},     {25'd0, pc},     m_pc);
    chk({tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, m_valid});
    chk({tag, ".instr"},  {16'd0, if_id_instr}, {16'd0, m_instr});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    if (m_valid) chk({tag, ".pc_inc"}, {25'd0, if_id_pc_inc}, m_pcinc);
  endtask

  // One clock edge: drive inputs, advance the model, compare afterwards.
  task automatic step(input logic s, input logic b, input logic [6:0] t, input logic r);
    int n_pc; bit n_halted; logic [15:0] n_instr; int n_pcinc; bit n_valid;
    stall = s; branch_taken = b; branch_target = t; resume = r;
    n_pc = m_pc; n_halted = m_halted; n_instr = m_instr; n_pcinc = m_pcinc; n_valid = m_valid;
    if (b) begin
      n_pc = int'(t); n_instr = 16'h0000; n_valid = 0; n_halted = 0;
      m_flushes++;
    end else if (m_halted) begin
      n_instr = 16'h0000; n_valid = 0;
      if (r) n_halted = 0;
    end else if (s) begin
      m_stalls++;
    end else begin
      n_pc = (m_pc + 1) % 128;
      n_instr = mem[m_pc];
      n_pcinc = (m_pc + 1) % 128;
      n_valid = 1;
      if (mem[m_pc][15:12] == 4'hF) n_halted = 1;
      m_fetched++;
    end
    @(posedge clk);
    m_pc = n_pc; m_halted = n_halted; m_instr = n_instr; m_pcinc = n_pcinc; m_valid = n_valid;
    #1;
    check_model("model");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; resume = 1'b0; branch_target = 7'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        s, b;
    logic [6:0]  t;
    logic        r;
    logic [6:0]  e_pc;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [6:0]  e_pcinc;
    logic        e_halt;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // stall, branch, target, resume | pc, valid, instr, pc_inc, halted
    tbl[0]  = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd1,   1'b1, 16'h1000, 7'd1,   1'b0};
    tbl[1]  = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd2,   1'b1, 16'h1001, 7'd2,   1'b0};
    tbl[2]  = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd3,   1'b1, 16'h1002, 7'd3,   1'b0};
    tbl[3]  = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd4,   1'b1, 16'h1003, 7'd4,   1'b0};
    tbl[4]  = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd5,   1'b1, 16'h1004, 7'd5,   1'b0};
    tbl[5]  = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd6,   1'b1, 16'hF123, 7'd6,   1'b1};
    tbl[6]  = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd6,   1'b0, 16'h0000, 7'd6,   1'b1};
    tbl[7]  = '{1'b0, 1'b0, 7'd0,   1'b1, 7'd6,   1'b0, 16'h0000, 7'd6,   1'b0};
    tbl[8]  = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd7,   1'b1, 16'h1006, 7'd7,   1'b0};
    tbl[9]  = '{1'b1, 1'b0, 7'd0,   1'b0, 7'd7,   1'b1, 16'h1006, 7'd7,   1'b0};
    tbl[10] = '{1'b1, 1'b0, 7'd0,   1'b0, 7'd7,   1'b1, 16'h1006, 7'd7,   1'b0};
    tbl[11] = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd8,   1'b1, 16'h1007, 7'd8,   1'b0};
    tbl[12] = '{1'b1, 1'b1, 7'd40,  1'b0, 7'd40,  1'b0, 16'h0000, 7'd8,   1'b0};
    tbl[13] = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd41,  1'b1, 16'h1028, 7'd41,  1'b0};
    tbl[14] = '{1'b0, 1'b1, 7'd126, 1'b0, 7'd126, 1'b0, 16'h0000, 7'd41,  1'b0};
    tbl[15] = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd127, 1'b1, 16'h107E, 7'd127, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd0,   1'b1, 16'h107F, 7'd0,   1'b0};
    tbl[17] = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd1,   1'b1, 16'h1000, 7'd1,   1'b0};
    tbl[18] = '{1'b0, 1'b0, 7'd0,   1'b1, 7'd2,   1'b1, 16'h1001, 7'd2,   1'b0};
  end

  initial begin
    for (int a = 0; a < 128; a++) mem[a] = 16'h1000 | 16'(a);
    mem[5] = 16'hF123;

    // ---------------- reset values ----------------
    do_reset();
    #1;
    chk("rst.pc",     {25'd0, pc}, 32'd0);
    chk("rst.valid",  {31'd0, if_id_valid}, 32'd0);
    chk("rst.instr",  {16'd0, if_id_instr}, 32'd0);
    chk("rst.pc_inc", {25'd0, if_id_pc_inc}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);

    // ---------------- directed table ----------------
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].r);
      chk($sformatf("tbl%0d.pc", i),     {25'd0, pc}, {25'd0, tbl[i].e_pc});
      chk($sformatf("tbl%0d.valid", i),  {31'd0, if_id_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d.instr", i),  {16'd0, if_id_instr}, {16'd0, tbl[i].e_instr});
      chk($sformatf("tbl%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].e_halt});
      if (tbl[i].e_valid)
        chk($sformatf("tbl%0d.pc_inc", i), {25'd0, if_id_pc_inc}, {25'd0, tbl[i].e_pcinc});
    end

    // ------- halted: stall ignored, resume+branch takes the target -------
    step(1'b0, 1'b1, 7'd5, 1'b0);
    step(1'b0, 1'b0, 7'd0, 1'b0);
    chk("halt2.halted", {31'd0, halted}, 32'd1);
    step(1'b1, 1'b0, 7'd0, 1'b0);
    chk("halt2.stall.pc",     {25'd0, pc}, 32'd6);
    chk("halt2.stall.valid",  {31'd0, if_id_valid}, 32'd0);
    step(1'b0, 1'b1, 7'd50, 1'b1);
    chk("resbr.pc",     {25'd0, pc}, 32'd50);
    chk("resbr.halted", {31'd0, halted}, 32'd0);
    step(1'b0, 1'b0, 7'd0, 1'b0);
    chk("resbr.instr", {16'd0, if_id_instr}, 32'h1032);

    // ------- asynchronous reset while halted -------
    step(1'b0, 1'b1, 7'd5, 1'b0);
    step(1'b0, 1'b0, 7'd0, 1'b0);
    step(1'b0, 1'b0, 7'd0, 1'b0);
    chk("pre_arst.halted", {31'd0, halted}, 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst.pc",     {25'd0, pc}, 32'd0);
    chk("arst.halted", {31'd0, halted}, 32'd0);
    chk("arst.valid",  {31'd0, if_id_valid}, 32'd0);
    chk("arst.instr",  {16'd0, if_id_instr}, 32'd0);
    do_reset();
    step(1'b0, 1'b0, 7'd0, 1'b0);
    chk("post_arst.pc",    {25'd0, pc}, 32'd1);
    chk("post_arst.instr", {16'd0, if_id_instr}, 32'h1000);

    // ------- randomized run against the model -------
    for (int a = 0; a < 128; a++) begin
      if ($urandom_range(0, 9) == 0) mem[a] = {4'hF, 12'($urandom)};
      else mem[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
    end
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
           7'($urandom), $urandom_range(0, 4) == 0);
    end

`ifdef FETCH_STATS_EN
    chk("stat.fetched", {16'd0, stat_fetched}, m_fetched);
    chk("stat.stalls",  {16'd0, stat_stalls},  m_stalls);
    chk("stat.flushes", {16'd0, stat_flushes}, m_flushes);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the program counter register and the IF/ID pipeline register.
- Drives the PC into the existing PC incrementer (pc -> pc_inc, +1, wraps modulo 2^7) and takes pc_inc back as the sequential next-PC.
- Selects next PC from sequential, branch redirect or hold (stall).
- Captures the fetched instruction for the decode stage, with bubble insertion on branch flush and a halt state machine.

Parameters:
- PC_W, 7, PC width; must match the incrementer (7).
- INSTR_W, 16, instruction word width.
- RESET_PC, 7'd0, PC value loaded on reset.
- HALT_OPCODE, 4'hF, value of instr[INSTR_W-1:INSTR_W-4] that halts fetch.
- NOP_INSTR, 16'h0000, instruction word inserted as a bubble.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pc  output  PC_W  current PC; feeds the incrementer and the instruction memory address.
- pc_inc  input  PC_W  pc+1 from the incrementer (combinational).
- imem_data  input  INSTR_W  instruction at address pc, combinational read.
- stall  input  1  hazard unit: hold PC and IF/ID.
- branch_taken  input  1  from EX: redirect to branch_target and flush IF/ID.
- branch_target  input  PC_W  redirect address.
- resume  input  1  leave HALTED state.
- if_id_instr  output  INSTR_W  registered instruction to decode.
- if_id_pc_inc  output  PC_W  registered pc_inc accompanying the instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch is halted.

Behaviour:
- Reset (reset_n=0, asynchronous, overrides everything):
  - pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_inc=0, if_id_valid=0, halted=0.
  - State machine goes to RUN.
- State machine, states RUN and HALTED:
  - RUN -> HALTED when a halt instruction is latched into IF/ID: imem_data opcode == HALT_OPCODE, no stall, no branch_taken.
  - HALTED -> RUN when resume=1 or branch_taken=1.
  - halted=1 exactly in HALTED.
- Next-PC priority each edge, highest first:
  1. branch_taken: pc <= branch_target.
  2. HALTED: pc holds.
  3. stall: pc holds.
  4. Otherwise: pc <= pc_inc.
- IF/ID update each edge, same priority:
  - branch_taken: instr=NOP_INSTR, valid=0 (flush, 1-cycle bubble).
  - HALTED: valid=0, instr=NOP_INSTR.
  - stall: all IF/ID fields hold.
  - Otherwise: instr=imem_data, pc_inc=pc_inc, valid=1.
- The halt instruction itself is passed to decode with valid=1. Following cycles are bubbles until resume or branch.
- Latency:
  - Instruction at address pc appears on if_id_instr one cycle after pc is presented.
  - Branch redirect: target fetched in the cycle after branch_taken; its instruction is in IF/ID two edges after branch_taken.
- Boundary conditions:
  - Wrap: pc=127 with no stall -> pc=0. No special case; the incrementer wraps.
  - stall and branch_taken together: branch wins; the stall is ignored for that edge.
  - resume and branch_taken together in HALTED: branch_target is used.
  - resume in RUN: ignored.
  - Reset mid-stall or mid-halt: immediate return to reset values. First fetch is from RESET_PC on the first edge after reset_n deasserts.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds outputs stat_fetched [15:0], stat_stalls [15:0], stat_flushes [15:0]. Each is a saturating counter, reset to 0 and held at 16'hFFFF once reached.
  - stat_fetched increments on each edge where if_id_valid is loaded with 1.
  - stat_stalls increments on each stall edge, in RUN with no branch_taken.
  - stat_flushes increments on each branch_taken edge.
- Not defined: the ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset then 5 free-run cycles, imem_data = address-derived -> pc goes 0,1,2,3,4,5; if_id_valid=1 from cycle 1; if_id_pc_inc = address+1.
- Start at pc=126, no stall, 3 edges -> pc = 127, 0, 1; if_id_pc_inc=0 after fetching address 127.
- stall=1 for 2 cycles at pc=10 -> pc stays 10; IF/ID unchanged; then resumes to 11.
- branch_taken=1 with target 7'd40 while stall=1 at pc=20 -> next pc=40, if_id_valid=0, if_id_instr=0; next edge captures instruction at 40.
- imem_data=16'hF123 at pc=5 -> IF/ID=F123 valid=1; then halted=1, pc stuck at 6, valid=0; resume=1 -> fetch continues at 6.
- Assert reset_n=0 asynchronously mid-cycle while HALTED -> pc=0, halted=0, valid=0 immediately, without waiting for a clock edge.
